int_arbiter: RTL

Interrupt arbiter and scheduler sitting in front of the interrupt sequencer, which pushes PSR and PC onto the stack and fetches the service-routine address. It collects device interrupt lines and the exception request, filters them by per-source enable and priority against the current PSR priority level, and picks one winner. It then raises `int_r` to the sequencer and holds it until the sequencer reports completion. On completion it acknowledges the winning source and writes the new priority level into the PSR.

---
 rtl/int_pkg.sv | 23 ++
 rtl/int_pri_encoder.sv | 37 +++
 rtl/int_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt arbiter.
//   state_t      : arbiter FSM states
//   PRI_W        : width of a priority level (matches PSR[10:8])
//   VEC_W        : width of an interrupt vector
//   IDX_W        : width of a source index (room for up to 8 sources)
//   DEF_VEC_BASE : default vector of device source 0
//   DEF_EXC_VEC  : default vector reported for exceptions
package int_pkg;

  localparam int PRI_W = 3;
  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  localparam logic [VEC_W-1:0] DEF_VEC_BASE = 8'h80;
  localparam logic [VEC_W-1:0] DEF_EXC_VEC  = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_t;

endpackage

// File: rtl/int_pri_encoder.sv
// Priority encoder over the eligible device sources.
//   elig    : mask of sources currently eligible
//   pri     : per-source priority levels
//   any     : at least one source is eligible
//   idx     : index of the winning source (highest pri, lowest index on tie)
//   win_pri : priority of the winning source
module int_pri_encoder
  import int_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]            elig,
  input  logic [N_SRC-1:0][PRI_W-1:0] pri,
  output logic                        any,
  output logic [IDX_W-1:0]            idx,
  output logic [PRI_W-1:0]            win_pri
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    any     = 1'b0;
    idx     = '0;
    win_pri = '0;
    // NOTE: blocking assignments here on purpose: each iteration must see the
    // running best left by the previous one.
    for (int i = 0; i < N_SRC; i++) begin
      // Strictly-greater keeps the earlier (lower) index on a tie.
      if (elig[i] && (!any || pri[i] > win_pri)) begin
        any     = 1'b1;
        idx     = IDX_W'(i);
        win_pri = pri[i];
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: filters device requests and the exception request,
// picks one winner, hands it to the interrupt sequencer and acknowledges it
// once the sequencer has finished its save/vector sequence.
//   clk, reset      : clock, asynchronous active-low reset
//   irq             : level-sensitive device requests
//   exc_req         : exception request, held until exc_ack
//   psr_pri         : current PSR priority level
//   take_ok         : pipeline can accept an interrupt this cycle
//   int_done        : sequencer completion pulse
//   cfg_we/idx/en/pri : per-source enable/priority configuration write
//   int_r, int_exc, int_vec : request, exception flag and vector to sequencer
//   int_ack, exc_ack        : one-cycle acknowledges to the winning source
//   psr_pri_new, psr_pri_we : new PSR priority and its write strobe
//   busy            : arbiter is not IDLE
module int_arbiter
  import int_pkg::*;
#(
  parameter int               N_SRC    = 4,
  parameter logic [VEC_W-1:0] VEC_BASE = DEF_VEC_BASE,
  parameter logic [VEC_W-1:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq,
  input  logic              exc_req,
  input  logic [PRI_W-1:0]  psr_pri,
  input  logic              take_ok,
  input  logic              int_done,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [PRI_W-1:0]  cfg_pri,
  output logic              int_r,
  output logic              int_exc,
  output logic [VEC_W-1:0]  int_vec,
  output logic [N_SRC-1:0]  int_ack,
  output logic              exc_ack,
  output logic [PRI_W-1:0]  psr_pri_new,
  output logic              psr_pri_we,
  output logic              busy
);

  logic [N_SRC-1:0]            en_q;
  logic [N_SRC-1:0][PRI_W-1:0] pri_q;
  logic [N_SRC-1:0]            elig;
  logic                        enc_any;
  logic [IDX_W-1:0]            enc_idx;
  logic [PRI_W-1:0]            enc_pri;

  state_t           state;
  logic [IDX_W-1:0] win_idx;
  logic [PRI_W-1:0] win_pri;
  logic             win_exc;

  // Config registers: writes to indices beyond N_SRC match no entry and
  // are dropped. They are accepted in any state; the FSM only reads them in
  // IDLE, so a latched winner is never disturbed.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the config array is reset because "all sources disabled" is the
    // required power-up state, not just a convenience.
    if (!reset) begin
      en_q  <= '0;
      pri_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          en_q[i]  <= cfg_en;
          pri_q[i] <= cfg_pri;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = irq[i] && en_q[i] && (pri_q[i] > psr_pri);
    end
  end

  int_pri_encoder #(.N_SRC(N_SRC)) u_enc (
    .elig    (elig),
    .pri     (pri_q),
    .any     (enc_any),
    .idx     (enc_idx),
    .win_pri (enc_pri)
  );

  // FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= IDLE;
      win_idx     <= '0;
      win_pri     <= '0;
      win_exc     <= 1'b0;
      int_r       <= 1'b0;
      int_exc     <= 1'b0;
      int_vec     <= '0;
      int_ack     <= '0;
      exc_ack     <= 1'b0;
      psr_pri_new <= '0;
      psr_pri_we  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Acknowledge and PSR strobes are single-cycle by default.
      int_ack    <= '0;
      exc_ack    <= 1'b0;
      psr_pri_we <= 1'b0;
      case (state)
        IDLE: begin
          if (take_ok && (exc_req || enc_any)) begin
            state <= REQ;
            int_r <= 1'b1;
            busy  <= 1'b1;
            if (exc_req) begin
              win_exc <= 1'b1;
              int_exc <= 1'b1;
              int_vec <= EXC_VEC;
            end else begin
              win_exc <= 1'b0;
              win_idx <= enc_idx;
              win_pri <= enc_pri;
              int_exc <= 1'b0;
              int_vec <= VEC_BASE + VEC_W'(enc_idx);
            end
          end
        end
        REQ: begin
          if (int_done) begin
            state <= ACK;
            int_r <= 1'b0;
            if (win_exc) begin
              exc_ack <= 1'b1;
            end else begin
              for (int i = 0; i < N_SRC; i++) begin
                int_ack[i] <= (win_idx == IDX_W'(i));
              end
              psr_pri_we  <= 1'b1;
              psr_pri_new <= win_pri;
            end
          end
        end
        ACK: begin
          // No evaluation here: IDLE must see the PSR level just written.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          int_r <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
